// File: rtl/linterp_ctrl_if.sv
// Bus between the IFFT sample stream, the linear-interpolator upsampler and linterp_ctrl.
// master = IFFT source plus upsampler side, slave = the sequencer.
interface linterp_ctrl_if #(
  parameter int dwidth = 16,
  parameter int iwidth = 5
);
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic [dwidth-1:0] s_real;
  logic [dwidth-1:0] s_imag;
  logic              li_dv_in;
  logic [iwidth-1:0] li_index_in;
  logic [dwidth-1:0] li_din_real;
  logic [dwidth-1:0] li_din_imag;
  logic [iwidth-1:0] li_index_out;

  modport master (
    output s_valid, s_last, s_real, s_imag,
    input  s_ready, li_dv_in, li_index_in, li_din_real, li_din_imag, li_index_out
  );

  modport slave (
    input  s_valid, s_last, s_real, s_imag,
    output s_ready, li_dv_in, li_index_in, li_din_real, li_din_imag, li_index_out
  );
endinterface

// File: rtl/linterp_ctrl.sv
// Sequencer for the linear-interpolator upsampler: writes IFFT bursts, sweeps index_out,
// and releases each burst's last sample only at a sweep boundary. Optional LINTERP_CTRL_STATS_EN adds counters.
module linterp_ctrl #(
  parameter int dwidth = 16,
  parameter int Nfft   = 32,
  parameter int iwidth = $clog2(Nfft)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  linterp_ctrl_if.slave        bus,
  input  logic                 out_ce,
  output logic                 frame_start,
  output logic                 underrun,
  output logic                 sync_err,
  input  logic                 clr_err
`ifdef LINTERP_CTRL_STATS_EN
  ,
  output logic [31:0]          frame_count,
  output logic [15:0]          underrun_count
`endif
);

  typedef enum logic [1:0] {OIDLE, SWAP, RUN} ostate_e;

  localparam logic [iwidth-1:0] LAST_IDX  = iwidth'(Nfft - 1);
  localparam logic [1:0]        SWAP_WAIT = 2'd1;

  ostate_e           ostate_q, ostate_d;
  logic [1:0]        scnt_q, scnt_d;
  logic [iwidth-1:0] rcnt_q, rcnt_d;
  logic [iwidth-1:0] wcnt_q, wcnt_d;
  logic              frame_start_q, frame_start_d;
  logic              underrun_q, underrun_d;
  logic              sync_err_q, sync_err_d;
  logic              li_dv_q, li_dv_d;
  logic [iwidth-1:0] li_index_in_q, li_index_in_d;
  logic [dwidth-1:0] din_real_q, din_real_d;
  logic [dwidth-1:0] din_imag_q, din_imag_d;

  logic swap_ok, s_ready, hs, at_last, lastacc, sync_set;

  // The last sample of a burst is held back until the running sweep is about to wrap.
  assign swap_ok = (ostate_q == OIDLE) ||
                   ((ostate_q == RUN) && out_ce && (rcnt_q == LAST_IDX));
  assign s_ready = resetn && enable && ((wcnt_q != LAST_IDX) || swap_ok);
  assign hs      = bus.s_valid && s_ready;
  assign at_last = (wcnt_q == LAST_IDX);
  assign lastacc = hs && at_last;

  // Input side: write counter, framing check and registered upsampler write port.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    wcnt_d        = wcnt_q;
    sync_set      = 1'b0;
    li_dv_d       = hs;
    li_index_in_d = li_index_in_q;
    din_real_d    = din_real_q;
    din_imag_d    = din_imag_q;
    if (hs) begin
      li_index_in_d = wcnt_q;
      din_real_d    = bus.s_real;
      din_imag_d    = bus.s_imag;
      if (at_last) begin
        wcnt_d   = '0;
        sync_set = !bus.s_last;
      end else if (bus.s_last) begin
        wcnt_d   = '0;
        sync_set = 1'b1;
      end else begin
        wcnt_d = wcnt_q + iwidth'(1);
      end
    end
    sync_err_d = sync_set || (sync_err_q && !clr_err);
  end

  // Output FSM: state register.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      ostate_q      <= OIDLE;
      scnt_q        <= '0;
      rcnt_q        <= '0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      ostate_q      <= ostate_d;
      scnt_q        <= scnt_d;
      rcnt_q        <= rcnt_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  // Output FSM: next state. SWAP covers the upsampler's write-to-dout latency.
  always_comb begin
    ostate_d = ostate_q;
    scnt_d   = scnt_q;
    unique case (ostate_q)
      OIDLE: begin
        if (lastacc) begin
          ostate_d = SWAP;
          scnt_d   = SWAP_WAIT;
        end
      end
      SWAP: begin
        if (scnt_q == 2'd0) ostate_d = RUN;
        else                scnt_d   = scnt_q - 2'd1;
      end
      RUN: begin
        if (out_ce && (rcnt_q == LAST_IDX) && lastacc) begin
          ostate_d = SWAP;
          scnt_d   = SWAP_WAIT;
        end
      end
      default: begin
        ostate_d = OIDLE;
        scnt_d   = '0;
      end
    endcase
  end

  // Output FSM: outputs. index_out freezes through SWAP and restarts at 0 with the new bank.
  always_comb begin
    rcnt_d        = rcnt_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    unique case (ostate_q)
      OIDLE: rcnt_d = '0;
      SWAP: begin
        if (scnt_q == 2'd0) begin
          rcnt_d        = '0;
          frame_start_d = 1'b1;
        end
      end
      RUN: begin
        if (out_ce) begin
          if (rcnt_q != LAST_IDX) begin
            rcnt_d = rcnt_q + iwidth'(1);
          end else if (!lastacc) begin
            rcnt_d     = '0;
            underrun_d = 1'b1;
          end
        end
      end
      default: rcnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt_q        <= '0;
      sync_err_q    <= 1'b0;
      li_dv_q       <= 1'b0;
      li_index_in_q <= '0;
      din_real_q    <= '0;
      din_imag_q    <= '0;
    end else begin
      wcnt_q        <= wcnt_d;
      sync_err_q    <= sync_err_d;
      li_dv_q       <= li_dv_d;
      li_index_in_q <= li_index_in_d;
      din_real_q    <= din_real_d;
      din_imag_q    <= din_imag_d;
    end
  end

`ifdef LINTERP_CTRL_STATS_EN
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] underrun_count_q, underrun_count_d;

  always_comb begin
    frame_count_d    = frame_count_q + 32'(frame_start_d);
    underrun_count_d = underrun_count_q;
    if (underrun_d && (underrun_count_q != 16'hFFFF))
      underrun_count_d = underrun_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_count_q    <= '0;
      underrun_count_q <= '0;
    end else begin
      frame_count_q    <= frame_count_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign frame_count    = frame_count_q;
  assign underrun_count = underrun_count_q;
`endif

  assign bus.s_ready      = s_ready;
  assign bus.li_dv_in     = li_dv_q;
  assign bus.li_index_in  = li_index_in_q;
  assign bus.li_din_real  = din_real_q;
  assign bus.li_din_imag  = din_imag_q;
  assign bus.li_index_out = rcnt_q;
  assign frame_start      = frame_start_q;
  assign underrun         = underrun_q;
  assign sync_err         = sync_err_q;

endmodule
